uc_mstack_reader: RTL and testbench
===================================

Name: uc_mstack_reader

Overview:
- Drains implied/decided literals from the UC arbiter's mstack queue and broadcasts each one to every enabled engine's UCQ_out queue.
- Engines consume at different rates, so delivery to each engine is tracked separately.
- A literal is popped from mstack only when the reader takes ownership of it. It is retired once every targeted engine has accepted it.
- Sits between the mstack and the `NUM_ENGINE per-engine UCQ_out queues.

Parameters:
- NUM_ENGINE, `NUM_ENGINE (4): number of engine UCQ_out queues.
- LIT_W, `LIT_IDX_MAX*2: literal width, matches lit_t.
- CNT_W, 32: width of the broadcast counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- mstack_empty  in  1  mstack has no entries.
- mstack_lit  in  LIT_W  mstack head; show-ahead, valid whenever mstack_empty=0.
- mstack_pop  out  1  pop the mstack head this cycle.
- engine_en  in  NUM_ENGINE  engines to target; sampled at load.
- flush  in  1  synchronous drop of the in-flight literal (backtrack/conflict).
- ucq_full  in  NUM_ENGINE  per-engine UCQ_out full.
- ucq_push  out  NUM_ENGINE  per-engine push strobe.
- ucq_lit  out  LIT_W  literal being broadcast; shared by all engines.
- busy  out  1  a literal is in flight (state BCAST).
- bcast_cnt  out  CNT_W  number of literals fully delivered.

Behaviour:
- Reset (async, rst=1): state=IDLE, hold_lit=0, pending=0, bcast_cnt=0. Outputs: mstack_pop=0, ucq_push=0, ucq_lit=0, busy=0.
- State IDLE:
  - Load occurs when mstack_empty=0 and flush=0.
  - On load: mstack_pop=1 for one cycle, hold_lit<=mstack_lit, pending<=engine_en.
  - If engine_en is nonzero, go to BCAST. If engine_en=0, the literal is popped and discarded; stay IDLE; bcast_cnt is unchanged.
  - Otherwise mstack_pop=0.
- State BCAST:
  - ucq_push[i] = pending[i] & ~ucq_full[i]. This is combinational from registered pending and the live full input.
  - ucq_lit = hold_lit, stable for the whole BCAST period.
  - pending <= pending & ~ucq_push.
  - An engine is pushed at most once per literal, never twice.
- Completion: the cycle in which (pending & ~ucq_push)==0.
  - bcast_cnt increments by 1 and wraps modulo 2^CNT_W.
  - Back-to-back load in the same cycle: if mstack_empty=0 and flush=0, the load rules apply (pop, latch, pending<=engine_en) and the state stays BCAST, or goes to IDLE if the new engine_en=0.
  - Otherwise go to IDLE.
  - Best-case throughput is 1 literal per cycle when no engine is full.
- Latency: a literal visible at mstack head in cycle N (IDLE) appears on ucq_push/ucq_lit in cycle N+1.
- Flush (any state) has priority over everything:
  - Outputs in that cycle: ucq_push=0, mstack_pop=0.
  - Next cycle: state<=IDLE, pending<=0. hold_lit keeps its value; bcast_cnt is unchanged.
  - Entries still in mstack are not dropped; the owner clears mstack separately.
- ucq_full held high on some engine: the reader stalls in BCAST indefinitely. Other engines still receive the literal exactly once. mstack is not popped during the stall.
- engine_en changing during BCAST has no effect on the in-flight literal.
- mstack_pop is never asserted when mstack_empty=1.
- Reset asserted mid-broadcast: all state clears immediately, with no push after rst rises.

Test Plan:
- Reset then idle: mstack_empty=1 for 10 cycles -> mstack_pop=0, ucq_push=0, busy=0, bcast_cnt=0 throughout.
- Single literal 0x0A, engine_en=4'b1111, all ucq_full=0 -> pop in cycle N; ucq_push=4'b1111 with ucq_lit=0x0A in N+1; bcast_cnt=1; back to IDLE.
- Staggered backpressure: literal 0x13, ucq_full=4'b0110 for 3 cycles then 0 -> push 4'b1001 in the first BCAST cycle; then 4'b0110 three cycles later; each engine pushed once; mstack popped once; bcast_cnt=1.
- Back-to-back: 4 literals 0x02,0x05,0x07,0x09 queued, no full -> one pop per cycle, each literal broadcast to all 4 engines in consecutive cycles; bcast_cnt=4.
- engine_en=4'b0000 with literal 0x21 present -> popped once, no ucq_push, bcast_cnt unchanged. Then engine_en=4'b0001 with 0x22 -> only ucq_push[0] fires.
- Flush in BCAST with ucq_full=4'b1111 holding literal 0x30 -> no push in flush cycle, IDLE next cycle, bcast_cnt unchanged. Next literal 0x31 is loaded normally. Async rst mid-BCAST -> outputs zero immediately.

Source files
------------

// File: rtl/uc_mstack_reader.sv
// Pops literals from the UC arbiter mstack and broadcasts each one to every
// enabled engine's UCQ_out queue, tracking per-engine delivery independently.
module uc_mstack_reader #(
  parameter int unsigned NUM_ENGINE = 4,
  parameter int unsigned LIT_W      = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mstack_empty,
  input  logic [LIT_W-1:0]      mstack_lit,
  output logic                  mstack_pop,
  input  logic [NUM_ENGINE-1:0] engine_en,
  input  logic                  flush,
  input  logic [NUM_ENGINE-1:0] ucq_full,
  output logic [NUM_ENGINE-1:0] ucq_push,
  output logic [LIT_W-1:0]      ucq_lit,
  output logic                  busy,
  output logic [CNT_W-1:0]      bcast_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BCAST = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [LIT_W-1:0]      hold_lit_q, hold_lit_d;
  logic [NUM_ENGINE-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_ENGINE-1:0] remain;
  logic                  load;

  always_comb begin
    state_d    = state_q;
    hold_lit_d = hold_lit_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    mstack_pop = 1'b0;
    ucq_push   = '0;
    remain     = '0;
    load       = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        IDLE: load = !mstack_empty;
        BCAST: begin
          ucq_push  = pending_q & ~ucq_full;
          remain    = pending_q & ~ucq_push;
          pending_d = remain;
          if (remain == '0) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!mstack_empty) load = 1'b1;
            else               state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      // A load from either state overrides the completion-side updates above.
      if (load) begin
        mstack_pop = 1'b1;
        hold_lit_d = mstack_lit;
        pending_d  = engine_en;
        state_d    = (engine_en != '0) ? BCAST : IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_lit_q <= '0;
      pending_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_lit_q <= hold_lit_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ucq_lit   = hold_lit_q;
  assign busy      = (state_q == BCAST);
  assign bcast_cnt = cnt_q;

endmodule

// File: tb/tb_uc_mstack_reader.sv
// Directed bench for uc_mstack_reader: a per-engine delivery model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_uc_mstack_reader;

  localparam int NE = 4;
  localparam int LW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mstack_empty;
  logic [LW-1:0] mstack_lit;
  logic          mstack_pop;
  logic [NE-1:0] engine_en;
  logic          flush;
  logic [NE-1:0] ucq_full;
  logic [NE-1:0] ucq_push;
  logic [LW-1:0] ucq_lit;
  logic          busy;
  logic [CW-1:0] bcast_cnt;

  uc_mstack_reader #(.NUM_ENGINE(NE), .LIT_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mstack_empty(mstack_empty), .mstack_lit(mstack_lit),
    .mstack_pop(mstack_pop), .engine_en(engine_en), .flush(flush),
    .ucq_full(ucq_full), .ucq_push(ucq_push), .ucq_lit(ucq_lit),
    .busy(busy), .bcast_cnt(bcast_cnt)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned passed = 0;

  logic [LW-1:0] mq[$];

  // Reference state: the literal in flight, which engines want it and which got it.
  bit            m_busy;
  logic [LW-1:0] m_lit;
  bit            m_target[NE];
  bit            m_done[NE];
  int unsigned   m_cnt;

  logic          s_pop, s_busy;
  logic [NE-1:0] s_push;
  logic [LW-1:0] s_lit;
  logic [CW-1:0] s_cnt;
  int unsigned   pcnt[NE];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_mstack();
    mstack_empty = (mq.size() == 0);
    mstack_lit   = (mq.size() == 0) ? '0 : mq[0];
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_lit  = '0;
    m_cnt  = 0;
    for (int i = 0; i < NE; i++) begin
      m_target[i] = 0;
      m_done[i]   = 0;
    end
  endtask

  // One clock cycle: check outputs against the model at the falling edge,
  // advance the model, then retire any popped entry after the rising edge.
  task automatic tick();
    logic [NE-1:0] ep;
    bit nd[NE];
    bit finished, take;
    @(negedge clk);
    ep = '0;
    finished = m_busy;
    for (int i = 0; i < NE; i++) begin
      if (!flush && m_busy && m_target[i] && !m_done[i] && !ucq_full[i]) ep[i] = 1'b1;
      nd[i] = m_done[i] || ep[i];
      if (m_target[i] && !nd[i]) finished = 0;
    end
    take = !flush && (!m_busy || finished) && (mq.size() > 0);

    s_pop = mstack_pop; s_push = ucq_push; s_lit = ucq_lit;
    s_busy = busy; s_cnt = bcast_cnt;
    for (int i = 0; i < NE; i++) if (ucq_push[i]) pcnt[i]++;

    chk("mstack_pop", {63'd0, mstack_pop}, {63'd0, take});
    chk("ucq_push", {60'd0, ucq_push}, {60'd0, ep});
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
    chk("bcast_cnt", {32'd0, bcast_cnt}, {32'd0, m_cnt});
    if (m_busy) chk("ucq_lit", {48'd0, ucq_lit}, {48'd0, m_lit});

    if (flush) m_busy = 0;
    else begin
      for (int i = 0; i < NE; i++) m_done[i] = nd[i];
      if (finished) begin
        m_cnt++;
        m_busy = 0;
      end
      if (take) begin
        m_lit  = mq[0];
        m_busy = (engine_en != '0);
        for (int i = 0; i < NE; i++) begin
          m_target[i] = engine_en[i];
          m_done[i]   = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (take) void'(mq.pop_front());
    drive_mstack();
  endtask

  task automatic clr_pcnt();
    for (int i = 0; i < NE; i++) pcnt[i] = 0;
  endtask

  initial begin
    engine_en = '0; flush = 1'b0; ucq_full = '0;
    drive_mstack();
    model_reset();
    clr_pcnt();
    #2;
    chk("rst_push", {60'd0, ucq_push}, 64'd0);
    chk("rst_pop", {63'd0, mstack_pop}, 64'd0);
    chk("rst_lit", {48'd0, ucq_lit}, 64'd0);
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Idle with empty mstack
    for (int k = 0; k < 10; k++) tick();
    chk("idle_cnt", {32'd0, s_cnt}, 64'd0);

    // Single literal to all engines
    engine_en = 4'b1111;
    mq.push_back(16'h000A); drive_mstack();
    tick();
    chk("single_pop", {63'd0, s_pop}, 64'd1);
    tick();
    chk("single_push", {60'd0, s_push}, 64'hF);
    chk("single_lit", {48'd0, s_lit}, 64'h0A);
    tick();
    chk("single_cnt", {32'd0, s_cnt}, 64'd1);
    chk("single_idle", {63'd0, s_busy}, 64'd0);

    // Staggered backpressure
    clr_pcnt();
    ucq_full = 4'b0110;
    mq.push_back(16'h0013); drive_mstack();
    tick();
    tick();
    chk("stag_first", {60'd0, s_push}, 64'h9);
    chk("stag_lit", {48'd0, s_lit}, 64'h13);
    tick(); tick();
    ucq_full = 4'b0000;
    tick();
    chk("stag_second", {60'd0, s_push}, 64'h6);
    tick();
    chk("stag_cnt", {32'd0, s_cnt}, 64'd2);
    for (int i = 0; i < NE; i++) chk("stag_once", 64'(pcnt[i]), 64'd1);

    // Back-to-back literals, one per cycle
    begin
      logic [LW-1:0] exp_lits[4];
      exp_lits[0] = 16'h02; exp_lits[1] = 16'h05; exp_lits[2] = 16'h07; exp_lits[3] = 16'h09;
      for (int i = 0; i < 4; i++) mq.push_back(exp_lits[i]);
      drive_mstack();
      tick();
      chk("b2b_pop0", {63'd0, s_pop}, 64'd1);
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("b2b_lit", {48'd0, s_lit}, {48'd0, exp_lits[i]});
        chk("b2b_push", {60'd0, s_push}, 64'hF);
        chk("b2b_pop", {63'd0, s_pop}, (i < 3) ? 64'd1 : 64'd0);
      end
      tick();
      chk("b2b_cnt", {32'd0, s_cnt}, 64'd6);
    end

    // No engines enabled: pop and discard, then a single engine
    engine_en = 4'b0000;
    mq.push_back(16'h0021); drive_mstack();
    tick();
    chk("en0_pop", {63'd0, s_pop}, 64'd1);
    tick();
    chk("en0_push", {60'd0, s_push}, 64'd0);
    chk("en0_busy", {63'd0, s_busy}, 64'd0);
    chk("en0_cnt", {32'd0, s_cnt}, 64'd6);
    engine_en = 4'b0001;
    mq.push_back(16'h0022); drive_mstack();
    tick();
    tick();
    chk("en1_push", {60'd0, s_push}, 64'h1);
    chk("en1_lit", {48'd0, s_lit}, 64'h22);
    tick();
    chk("en1_cnt", {32'd0, s_cnt}, 64'd7);

    // Flush while stalled; queued entry must not be popped in the flush cycle
    engine_en = 4'b1111;
    ucq_full  = 4'b1111;
    mq.push_back(16'h0030); drive_mstack();
    tick();
    tick();
    chk("stall_push", {60'd0, s_push}, 64'd0);
    mq.push_back(16'h0031); drive_mstack();
    engine_en = 4'b0011;
    tick();
    chk("stall_nopop", {63'd0, s_pop}, 64'd0);
    flush = 1'b1;
    tick();
    chk("flush_push", {60'd0, s_push}, 64'd0);
    chk("flush_pop", {63'd0, s_pop}, 64'd0);
    flush = 1'b0; ucq_full = 4'b0000; engine_en = 4'b1111;
    tick();
    chk("post_flush_idle", {63'd0, s_busy}, 64'd0);
    chk("post_flush_pop", {63'd0, s_pop}, 64'd1);
    chk("post_flush_cnt", {32'd0, s_cnt}, 64'd7);
    tick();
    chk("next_lit", {48'd0, s_lit}, 64'h31);
    chk("next_push", {60'd0, s_push}, 64'hF);
    tick();
    chk("next_cnt", {32'd0, s_cnt}, 64'd8);

    // Asynchronous reset in the middle of a broadcast
    ucq_full = 4'b1111;
    mq.push_back(16'h0040); drive_mstack();
    tick();
    ucq_full = 4'b0000;
    #1;
    chk("pre_rst_push", {60'd0, ucq_push}, 64'hF);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_push", {60'd0, ucq_push}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_cnt", {32'd0, bcast_cnt}, 64'd0);
    chk("arst_lit", {48'd0, ucq_lit}, 64'd0);
    model_reset();
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    chk("after_rst_cnt", {32'd0, s_cnt}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
